// File: rtl/image_filter_pipe_pkg.sv
// Shared types and constants for the image filter pipeline:
// output mode encoding and the fixed-point luma coefficients.
package image_filter_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_GREY = 2'd1,
        MODE_BIN  = 2'd2,
        MODE_INV  = 2'd3
    } mode_e;

    // grey = (77*R + 150*G + 29*B) >> 8
    localparam int unsigned LUMA_R     = 77;
    localparam int unsigned LUMA_G     = 150;
    localparam int unsigned LUMA_B     = 29;
    localparam int unsigned LUMA_SHIFT = 8;

endpackage

// File: rtl/image_filter_pipe_if.sv
// Video/control bundle between capture, the filter and the frame/overlay stage.
// master drives pixels and control, slave is the filter.
interface image_filter_pipe_if #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned CNT_W = 12
);
    logic                 HSync;
    logic                 Enable;
    logic [3*PIX_W-1:0]   RGBin;
    logic [1:0]           Mode;
    logic [PIX_W-1:0]     ThreshIn;
    logic                 ThreshLoad;
    logic [3*PIX_W-1:0]   RGBout;
    logic                 HSyncOut;
    logic                 EnableOut;
    logic [CNT_W-1:0]     LineCount;
    logic                 CountValid;

    modport master (
        output HSync, Enable, RGBin, Mode, ThreshIn, ThreshLoad,
        input  RGBout, HSyncOut, EnableOut, LineCount, CountValid
    );

    modport slave (
        input  HSync, Enable, RGBin, Mode, ThreshIn, ThreshLoad,
        output RGBout, HSyncOut, EnableOut, LineCount, CountValid
    );
endinterface

// File: rtl/image_filter_pipe_luma_conv.sv
// Stage 1 of the filter: registered RGB -> luma conversion, with the
// RGB word delayed alongside so pass-through mode stays aligned.
module luma_conv
    import image_filter_pkg::*;
#(
    parameter int unsigned PIX_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3*PIX_W-1:0] rgb_in,
    output logic [PIX_W-1:0]   grey,
    output logic [3*PIX_W-1:0] rgb_out
);
    localparam int unsigned SUM_W = PIX_W + LUMA_SHIFT;

    logic [SUM_W-1:0] sum;

    // Weighted channel sum; coefficients total 256 so the sum never overflows SUM_W
    always_comb begin
        sum = SUM_W'(LUMA_R) * SUM_W'(rgb_in[3*PIX_W-1 -: PIX_W])
            + SUM_W'(LUMA_G) * SUM_W'(rgb_in[2*PIX_W-1 -: PIX_W])
            + SUM_W'(LUMA_B) * SUM_W'(rgb_in[PIX_W-1:0]);
    end

    // Register grey and the untouched RGB word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grey    <= '0;
            rgb_out <= '0;
        end else begin
            grey    <= PIX_W'(sum >> LUMA_SHIFT);
            rgb_out <= rgb_in;
        end
    end

endmodule

// File: rtl/image_filter_pipe.sv
// Two-stage greyscale/threshold filter with per-line white-pixel counting.
// Threshold and mode are shadowed and only take effect at an input line start.
// Build option: define IMG_FILT_HYST_EN to make "white" a per-line hysteresis
// state (set at grey>=thresh, cleared below thresh-HYST); otherwise stateless.
module image_filter_pipe
    import image_filter_pkg::*;
#(
    parameter int unsigned PIX_W          = 8,
    parameter int unsigned THRESH_DEFAULT = 172,
    parameter int unsigned CNT_W          = 12,
    parameter int unsigned HYST           = 8
) (
    input logic                clk,
    input logic                rst,
    image_filter_pipe_if.slave bus
);
`ifdef IMG_FILT_HYST_EN
    localparam bit HYST_ON = 1'b1;
`else
    localparam bit HYST_ON = 1'b0;
`endif
    localparam logic [PIX_W-1:0] THR_RST = PIX_W'(THRESH_DEFAULT);
    localparam logic [PIX_W-1:0] HYST_W  = PIX_W'(HYST);

    // stage 1
    logic [PIX_W-1:0]   grey_s1;
    logic [3*PIX_W-1:0] rgb_s1;
    logic               hs_s1;
    logic               en_s1;

    // shadowed controls
    logic [PIX_W-1:0]   thr_pend;
    logic [PIX_W-1:0]   thr_act;
    mode_e              mode_pend;
    mode_e              mode_act;
    logic               line_start_in;

    // stage 2
    logic               line_start_s2;
    logic [PIX_W-1:0]   thr_lo;
    logic               hyst_q;
    logic               white;
    logic [3*PIX_W-1:0] pix_s2;
    logic [3*PIX_W-1:0] rgb_out;
    logic               hs_out;
    logic               en_out;
    logic               white_out;

    // line counter
    logic               hs_out_d;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   line_cnt;
    logic               cnt_valid;

    luma_conv #(
        .PIX_W (PIX_W)
    ) u_luma (
        .clk     (clk),
        .rst     (rst),
        .rgb_in  (bus.RGBin),
        .grey    (grey_s1),
        .rgb_out (rgb_s1)
    );

    // Delay sync/valid through stage 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_s1 <= 1'b0;
            en_s1 <= 1'b0;
        end else begin
            hs_s1 <= bus.HSync;
            en_s1 <= bus.Enable;
        end
    end

    assign line_start_in = bus.HSync & ~hs_s1;

    // Pending regs capture every load; active regs change only at line start,
    // where a simultaneous load bypasses the pending copy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thr_pend  <= THR_RST;
            thr_act   <= THR_RST;
            mode_pend <= MODE_BIN;
            mode_act  <= MODE_BIN;
        end else begin
            if (bus.ThreshLoad) begin
                thr_pend  <= bus.ThreshIn;
                mode_pend <= mode_e'(bus.Mode);
            end
            if (line_start_in) begin
                thr_act  <= bus.ThreshLoad ? bus.ThreshIn : thr_pend;
                mode_act <= bus.ThreshLoad ? mode_e'(bus.Mode) : mode_pend;
            end
        end
    end

    assign line_start_s2 = hs_s1 & ~hs_out;
    assign thr_lo        = (thr_act > HYST_W) ? thr_act - HYST_W : '0;

    // White decision: stateless compare, or hysteresis that resets per line and holds while Enable is low
    always_comb begin
        white = line_start_s2 ? 1'b0 : hyst_q;
        if (!HYST_ON) begin
            white = (grey_s1 >= thr_act);
        end else if (en_s1) begin
            if (grey_s1 >= thr_act) begin
                white = 1'b1;
            end else if (grey_s1 < thr_lo) begin
                white = 1'b0;
            end
        end
    end

    // Output pixel selection by active mode; blanked when not valid
    always_comb begin
        pix_s2 = '0;
        if (en_s1) begin
            case (mode_act)
                MODE_PASS: pix_s2 = rgb_s1;
                MODE_GREY: pix_s2 = {3{grey_s1}};
                MODE_BIN:  pix_s2 = white ? '1 : '0;
                MODE_INV:  pix_s2 = white ? '0 : '1;
                default:   pix_s2 = '0;
            endcase
        end
    end

    // Stage 2 registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_out   <= '0;
            hs_out    <= 1'b0;
            en_out    <= 1'b0;
            white_out <= 1'b0;
            hyst_q    <= 1'b0;
        end else begin
            rgb_out   <= pix_s2;
            hs_out    <= hs_s1;
            en_out    <= en_s1;
            white_out <= white;
            hyst_q    <= white;
        end
    end

    // Per-line white counter on the output side; the edge pixel starts the new line's count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_out_d  <= 1'b0;
            cnt       <= '0;
            line_cnt  <= '0;
            cnt_valid <= 1'b0;
        end else begin
            hs_out_d  <= hs_out;
            cnt_valid <= 1'b0;
            if (hs_out & ~hs_out_d) begin
                line_cnt  <= cnt;
                cnt_valid <= 1'b1;
                cnt       <= CNT_W'(white_out & en_out);
            end else if (white_out && en_out && (cnt != '1)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.RGBout     = rgb_out;
    assign bus.HSyncOut   = hs_out;
    assign bus.EnableOut  = en_out;
    assign bus.LineCount  = line_cnt;
    assign bus.CountValid = cnt_valid;

endmodule

// File: tb/tb_image_filter_pipe.sv
// Scoreboard bench for image_filter_pipe: a reference model predicts each
// output pixel and each line count when stimulus is driven; the DUT outputs
// are compared as they appear. A second instance with CNT_W=3 shares the
// stimulus to exercise counter saturation.
module tb_image_filter_pipe;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    image_filter_pipe_if #(.PIX_W(8), .CNT_W(12)) bus0 ();
    image_filter_pipe_if #(.PIX_W(8), .CNT_W(3))  bus1 ();

    image_filter_pipe #(
        .PIX_W(8), .THRESH_DEFAULT(172), .CNT_W(12), .HYST(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    image_filter_pipe #(
        .PIX_W(8), .THRESH_DEFAULT(172), .CNT_W(3), .HYST(8)
    ) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    assign bus1.HSync      = bus0.HSync;
    assign bus1.Enable     = bus0.Enable;
    assign bus1.RGBin      = bus0.RGBin;
    assign bus1.Mode       = bus0.Mode;
    assign bus1.ThreshIn   = bus0.ThreshIn;
    assign bus1.ThreshLoad = bus0.ThreshLoad;

    typedef struct {
        int          due;
        logic [23:0] rgb;
        logic        hs;
        logic        en;
    } pix_t;

    typedef struct {
        int due;
        int cnt;
    } cnt_t;

    pix_t pq[$];
    cnt_t cq[$];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // reference model state
    bit m_hs_prev;
    int m_pth, m_ath, m_pmd, m_amd, m_cnt;
    bit m_hw;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    function automatic logic [23:0] gry(input int v);
        logic [7:0] b;
        b = 8'(v);
        return {b, b, b};
    endfunction

    task automatic model_reset();
        pq.delete();
        cq.delete();
        m_hs_prev = 1'b0;
        m_pth = 172; m_ath = 172;
        m_pmd = 2;   m_amd = 2;
        m_cnt = 0;
        m_hw  = 1'b0;
    endtask

    task automatic monitor();
        pix_t p;
        cnt_t c;
        if (pq.size() > 0 && pq[0].due == cyc) begin
            p = pq.pop_front();
            check_eq("rgbout",     bus0.RGBout,    p.rgb);
            check_eq("hsyncout",   bus0.HSyncOut,  p.hs);
            check_eq("enableout",  bus0.EnableOut, p.en);
            check_eq("rgbout_sat", bus1.RGBout,    p.rgb);
        end
        if (cq.size() > 0 && cq[0].due < cyc) begin
            c = cq.pop_front();
            check_eq("countvalid_when", cyc, c.due);
        end
        if (bus0.CountValid) begin
            if (cq.size() == 0) begin
                check_eq("countvalid_spurious", bus0.CountValid, 0);
            end else begin
                c = cq.pop_front();
                check_eq("countvalid_when",  cyc,             c.due);
                check_eq("linecount",        bus0.LineCount,  sat(c.cnt, 4095));
                check_eq("countvalid_sat",   bus1.CountValid, 1);
                check_eq("linecount_sat",    bus1.LineCount,  sat(c.cnt, 7));
            end
        end else if (bus1.CountValid) begin
            check_eq("countvalid_sat_spurious", bus1.CountValid, 0);
        end
    endtask

    task automatic step(input bit hs, input bit en, input logic [23:0] rgb,
                        input bit ld = 1'b0, input int th = 0, input int md = 0);
        int r, g, b, grey, a_th, a_md, lo;
        bit ls, w;
        logic [23:0] e;
        pix_t p;
        cnt_t c;

        @(negedge clk);
        cyc++;
        monitor();

        bus0.HSync      = hs;
        bus0.Enable     = en;
        bus0.RGBin      = rgb;
        bus0.ThreshLoad = ld;
        bus0.ThreshIn   = 8'(th);
        bus0.Mode       = 2'(md);

        ls = hs & ~m_hs_prev;
        if (ls) begin
            a_th = ld ? th : m_pth;
            a_md = ld ? md : m_pmd;
        end else begin
            a_th = m_ath;
            a_md = m_amd;
        end
        m_ath = a_th;
        m_amd = a_md;
        if (ld) begin
            m_pth = th;
            m_pmd = md;
        end
        m_hs_prev = hs;

        r = int'(rgb[23:16]);
        g = int'(rgb[15:8]);
        b = int'(rgb[7:0]);
        grey = (77 * r + 150 * g + 29 * b) >> 8;

`ifdef IMG_FILT_HYST_EN
        lo = (a_th > 8) ? a_th - 8 : 0;
        if (ls) m_hw = 1'b0;
        if (en) begin
            if (grey >= a_th) m_hw = 1'b1;
            else if (grey < lo) m_hw = 1'b0;
        end
        w = m_hw;
`else
        lo = 0;
        w = (grey >= a_th);
`endif

        if (!en) e = 24'h0;
        else begin
            case (a_md)
                0:       e = rgb;
                1:       e = gry(grey);
                2:       e = w ? 24'hFFFFFF : 24'h0;
                default: e = w ? 24'h0 : 24'hFFFFFF;
            endcase
        end

        if (ls) begin
            c.due = cyc + 3;
            c.cnt = m_cnt;
            cq.push_back(c);
            m_cnt = int'(w & en);
        end else if (w & en) begin
            m_cnt++;
        end

        p.due = cyc + 2;
        p.rgb = e;
        p.hs  = hs;
        p.en  = en;
        pq.push_back(p);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_rgbout",     bus0.RGBout,     0);
        check_eq("rst_hsyncout",   bus0.HSyncOut,   0);
        check_eq("rst_enableout",  bus0.EnableOut,  0);
        check_eq("rst_linecount",  bus0.LineCount,  0);
        check_eq("rst_countvalid", bus0.CountValid, 0);
        bus0.HSync      = 1'b0;
        bus0.Enable     = 1'b0;
        bus0.RGBin      = '0;
        bus0.ThreshLoad = 1'b0;
        bus0.ThreshIn   = '0;
        bus0.Mode       = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bus0.HSync      = 1'b0;
        bus0.Enable     = 1'b0;
        bus0.RGBin      = '0;
        bus0.ThreshLoad = 1'b0;
        bus0.ThreshIn   = '0;
        bus0.Mode       = '0;
        model_reset();

        do_reset();

        // default threshold 172, binary mode
        step(1, 1, gry(172));
        step(0, 1, gry(171));
        step(0, 0, gry(200));
        step(0, 1, gry(172));
        step(0, 1, gry(10), 1, 172, 1);

        // grey mode takes effect at the next line
        step(1, 1, 24'hFF0000);
        step(0, 1, 24'h00FF00);
        step(0, 1, 24'hFFFFFF);
        step(0, 1, 24'h0000FF, 1, 172, 2);

        // mid-line load of 50 is deferred to the next line
        step(1, 1, gry(100));
        step(0, 1, gry(100), 1, 50, 2);
        step(0, 1, gry(100));
        step(0, 1, gry(100));
        step(1, 1, gry(100));
        step(0, 1, gry(100));

        // load on the line-start cycle applies to that line: 1 black + 10 white + 5 black
        step(1, 1, gry(100), 1, 200, 2);
        for (int i = 0; i < 10; i++) step(0, 1, gry(255));
        for (int i = 0; i < 5; i++)  step(0, 1, gry(0));

        // inverted mode then pass-through
        step(1, 1, gry(200), 1, 128, 3);
        step(0, 1, gry(50));
        step(0, 1, 24'hA55A3C, 1, 128, 0);
        step(1, 1, 24'hA55A3C);
        step(0, 0, 24'h123456);
        step(0, 1, 24'h123456);

        // hysteresis band around 100
        step(1, 1, gry(0), 1, 100, 2);
        step(0, 1, gry(100));
        step(0, 1, gry(95));
        step(0, 1, gry(91));
        step(0, 0, gry(0));
        step(0, 1, gry(91));
        step(0, 1, gry(93));

        // random traffic
        for (int i = 0; i < 120; i++) begin
            step(($urandom_range(0, 9) == 0), ($urandom_range(0, 4) != 0),
                 24'($urandom()), ($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
        end

        // reset mid-line, threshold reverts to 172
        step(1, 1, gry(200), 1, 100, 2);
        step(0, 1, gry(150));
        step(0, 1, gry(150));
        do_reset();
        step(0, 1, gry(172));
        step(0, 1, gry(171));
        step(0, 1, gry(255));
        step(1, 1, gry(171));
        step(0, 1, gry(172));

        // flush the last line
        step(1, 0, gry(0));
        for (int i = 0; i < 4; i++) step(0, 0, gry(0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cyc++;
            monitor();
        end
        check_eq("pixel_queue_left", pq.size(), 0);
        check_eq("count_queue_left", cq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
